// File: rtl/qsys_pio_key_in_irq.sv
// Avalon-MM s1 input PIO: 2-FF synchroniser, per-bit debouncer, edge capture
// with write-1-to-clear, interrupt mask and a level irq to the Nios II.
module qsys_pio_key_in_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] debdly_q, debdly_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ec_q, ec_d;

    logic             wr_en_c;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;
    logic [WIDTH-1:0] cap_c;
    logic [WIDTH-1:0] clr_c;

    // Next-state: synchroniser, debouncer, edge capture and register writes
    always_comb begin
        sync1_d  = in_port;
        sync2_d  = sync1_q;
        debdly_d = deb_q;
        deb_d    = deb_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        rise_c = deb_q & ~debdly_q;
        fall_c = ~deb_q & debdly_q;
        case (EDGE_TYPE)
            32'd0:   cap_c = rise_c;
            32'd1:   cap_c = fall_c;
            default: cap_c = rise_c | fall_c;
        endcase

        wr_en_c = chipselect & ~write_n;
        mask_d  = (wr_en_c && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
        clr_c   = (wr_en_c && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        // A capture in the same cycle as a clear wins
        ec_d    = (ec_q & ~clr_c) | cap_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= IDLE_VEC;
            sync2_q  <= IDLE_VEC;
            deb_q    <= IDLE_VEC;
            debdly_q <= IDLE_VEC;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
            mask_q   <= '0;
            ec_q     <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            debdly_q <= debdly_d;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
            mask_q   <= mask_d;
            ec_q     <= ec_d;
        end
    end

    // Read mux is side-effect free and ignores chipselect
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(deb_q);
            2'd2:    readdata = 32'(mask_q);
            2'd3:    readdata = 32'(ec_q);
            default: readdata = '0;
        endcase
    end

    assign irq = |(ec_q & mask_q);

endmodule

// File: tb/tb_qsys_pio_key_in_irq.sv
// Directed bench for qsys_pio_key_in_irq (WIDTH=4, DEBOUNCE_CYCLES=4, falling edge).
module tb_qsys_pio_key_in_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic        is_irq;
        logic [1:0]  addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q [$];

    qsys_pio_key_in_irq #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(16), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    // Push expectation, then pop and compare against the DUT output
    task automatic expect_rd(input string tag, input logic [1:0] a, input logic [31:0] e);
        exp_t x;
        sb_q.push_back('{tag: tag, is_irq: 1'b0, addr: a, exp: e});
        x = sb_q.pop_front();
        address = x.addr;
        #1;
        tests++;
        assert (readdata === x.exp) else begin
            fails++;
            $error("FAIL %s: readdata=0x%08h expected 0x%08h", x.tag, readdata, x.exp);
        end
    endtask

    task automatic expect_irq(input string tag, input logic e);
        exp_t x;
        sb_q.push_back('{tag: tag, is_irq: 1'b1, addr: 2'd0, exp: 32'(e)});
        x = sb_q.pop_front();
        #1;
        tests++;
        assert (irq === x.exp[0]) else begin
            fails++;
            $error("FAIL %s: irq=%b expected %b", x.tag, irq, x.exp[0]);
        end
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 4'hF;
        tick(3);
        expect_rd("rst_data", 2'd0, 32'h0000_000F);
        expect_rd("rst_rsvd", 2'd1, 32'h0);
        expect_rd("rst_mask", 2'd2, 32'h0);
        expect_rd("rst_ec",   2'd3, 32'h0);
        expect_irq("rst_irq", 1'b0);
        reset_n = 1'b1;
        tick(10);
        expect_rd("idle_data", 2'd0, 32'h0000_000F);
        expect_rd("idle_ec",   2'd3, 32'h0);
        expect_irq("idle_irq", 1'b0);

        // Mask upper bits read 0; data and reserved ignore writes
        wr(2'd2, 32'hFFFF_FFFF);
        expect_rd("mask_width", 2'd2, 32'h0000_000F);
        wr(2'd0, 32'h0); wr(2'd1, 32'hFFFF_FFFF);
        expect_rd("data_ro", 2'd0, 32'h0000_000F);
        expect_rd("rsvd_ro", 2'd1, 32'h0);
        wr(2'd2, 32'h1);

        // Falling edge latency on bit 0
        in_port = 4'hE;
        tick(5);
        expect_rd("lat_data_e4", 2'd0, 32'h0000_000F);
        tick();
        expect_rd("lat_data_e5", 2'd0, 32'h0000_000E);
        expect_rd("lat_ec_e5",   2'd3, 32'h0);
        expect_irq("lat_irq_e5", 1'b0);
        tick();
        expect_rd("lat_ec_e6",   2'd3, 32'h1);
        expect_irq("lat_irq_e6", 1'b1);
        wr(2'd3, 32'h1);
        expect_rd("w1c_ec", 2'd3, 32'h0);
        expect_irq("w1c_irq", 1'b0);

        // Bounce on bit 1 never qualifies
        for (int r = 0; r < 5; r++) begin
            in_port[1] = 1'b0; tick(3);
            in_port[1] = 1'b1; tick(2);
        end
        tick(8);
        expect_rd("bounce_data", 2'd0, 32'h0000_000E);
        expect_rd("bounce_ec",   2'd3, 32'h0);

        // Rising edge is not captured; masked falling edge holds irq low
        wr(2'd2, 32'h0);
        in_port[0] = 1'b1; tick(10);
        expect_rd("rise_data", 2'd0, 32'h0000_000F);
        expect_rd("rise_ec",   2'd3, 32'h0);
        in_port[0] = 1'b0; tick(10);
        expect_rd("masked_ec", 2'd3, 32'h1);
        expect_irq("masked_irq", 1'b0);
        wr(2'd2, 32'h1);
        expect_irq("unmask_irq", 1'b1);
        wr(2'd3, 32'h1);
        expect_rd("clr_ec", 2'd3, 32'h0);
        expect_irq("clr_irq", 1'b0);

        // Capture coinciding with W1C: set wins
        in_port[0] = 1'b1; tick(10);
        in_port[0] = 1'b0; tick(6);
        wr(2'd3, 32'h1);
        expect_rd("race_ec", 2'd3, 32'h1);
        expect_irq("race_irq", 1'b1);
        wr(2'd3, 32'h1);
        expect_rd("race_clr", 2'd3, 32'h0);

        // Reset mid-count discards the pending change
        in_port[0] = 1'b1; tick(10);
        in_port[0] = 1'b0; tick(4);
        reset_n = 1'b0; tick(2);
        expect_rd("mid_rst_data", 2'd0, 32'h0000_000F);
        expect_rd("mid_rst_mask", 2'd2, 32'h0);
        reset_n = 1'b1;
        tick(5);
        expect_rd("requal_e4", 2'd0, 32'h0000_000F);
        tick();
        expect_rd("requal_e5", 2'd0, 32'h0000_000E);
        tick();
        expect_rd("requal_ec", 2'd3, 32'h1);
        expect_irq("requal_irq", 1'b0);
        expect_rd("rsvd_end", 2'd1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
